message_compose_buffer: RTL and testbench

//  Upstream stage of gpio_protocol's message_out. Collects ASCII keystrokes (key2ascii output,

---
 rtl/message_compose_buffer_if.sv | 25 ++
 rtl/message_compose_buffer.sv | 97 +++++++++
 tb/tb_message_compose_buffer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/message_compose_buffer_if.sv
// Key-entry and send-handshake bundle between the compose buffer and its neighbours.
// The slave side is the buffer itself, and the master side is the key source or link consumer.
interface message_compose_buffer_if #(
  parameter int N_CHARS = 16
);
  logic                   key_valid;
  logic [7:0]             key_ascii;
  logic                   clear;
  logic [8*N_CHARS-1:0]   message;
  logic [4:0]             char_count;
  logic                   send_valid;
  logic                   send_ready;
  logic                   msg_changed;
  logic                   key_dropped;

  modport slave (
    input  key_valid, key_ascii, clear, send_ready,
    output message, char_count, send_valid, msg_changed, key_dropped
  );

  modport master (
    output key_valid, key_ascii, clear, send_ready,
    input  message, char_count, send_valid, msg_changed, key_dropped
  );
endinterface

// File: rtl/message_compose_buffer.sv
// Builds a space-padded ASCII message from keystrokes and offers it with valid/ready on ENTER.
// Key and accept effects land 1 cycle later; while send_valid waits for send_ready, the message stays frozen and incoming keys are dropped.
module message_compose_buffer #(
  parameter int         N_CHARS   = 16,
  parameter logic [7:0] PAD_CHAR  = 8'h20,
  parameter logic [7:0] KEY_ENTER = 8'h0D,
  parameter logic [7:0] KEY_BKSP  = 8'h08
) (
  input logic                    clock,
  input logic                    reset,
  message_compose_buffer_if.slave bus
);
  localparam int                 MSG_W   = 8 * N_CHARS;
  localparam logic [MSG_W-1:0]   PAD_MSG = {N_CHARS{PAD_CHAR}};

  typedef enum logic {EDIT, SEND} state_t;

  state_t           state, state_nxt;
  logic [MSG_W-1:0] msg, msg_nxt;
  logic [4:0]       count, count_nxt;
  logic             changed, changed_nxt;
  logic             dropped, dropped_nxt;
  logic             printable;
  logic             full;

  assign printable = (bus.key_ascii >= 8'h20) && (bus.key_ascii <= 8'h7E);
  assign full      = (count == 5'(N_CHARS));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= EDIT;
      msg     <= PAD_MSG;
      count   <= '0;
      changed <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_nxt;
      msg     <= msg_nxt;
      count   <= count_nxt;
      changed <= changed_nxt;
      dropped <= dropped_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    msg_nxt     = msg;
    count_nxt   = count;
    changed_nxt = 1'b0;
    dropped_nxt = 1'b0;
    if (bus.clear) begin
      // A key arriving with clear is swallowed silently.
      state_nxt   = EDIT;
      msg_nxt     = PAD_MSG;
      count_nxt   = '0;
      changed_nxt = (count != 5'd0);
    end else if (state == SEND) begin
      if (bus.send_ready) begin
        state_nxt   = EDIT;
        msg_nxt     = PAD_MSG;
        count_nxt   = '0;
        changed_nxt = 1'b1;
      end
      dropped_nxt = bus.key_valid;
    end else if (bus.key_valid) begin
      if (printable) begin
        if (full) begin
          dropped_nxt = 1'b1;
        end else begin
          for (int i = 0; i < N_CHARS; i++) begin
            if (count == 5'(i)) msg_nxt[8*i +: 8] = bus.key_ascii;
          end
          count_nxt   = count + 5'd1;
          changed_nxt = 1'b1;
        end
      end else if (bus.key_ascii == KEY_BKSP) begin
        if (count != 5'd0) begin
          for (int i = 0; i < N_CHARS; i++) begin
            if (count == 5'(i + 1)) msg_nxt[8*i +: 8] = PAD_CHAR;
          end
          count_nxt   = count - 5'd1;
          changed_nxt = 1'b1;
        end
      end else if (bus.key_ascii == KEY_ENTER) begin
        if (count != 5'd0) state_nxt = SEND;
      end else begin
        dropped_nxt = 1'b1;
      end
    end
  end

  assign bus.message     = msg;
  assign bus.char_count  = count;
  assign bus.send_valid  = (state == SEND);
  assign bus.msg_changed = changed;
  assign bus.key_dropped = dropped;
endmodule

// File: tb/tb_message_compose_buffer.sv
// Self-checking bench: directed scenarios plus random keystrokes against a queue-based message model.
module tb_message_compose_buffer;
  localparam int N = 16;

  logic clock;
  logic reset;

  message_compose_buffer_if #(.N_CHARS(N)) bus ();

  message_compose_buffer #(.N_CHARS(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: text typed so far, plus whether it is awaiting acceptance.
  logic [7:0] text[$];
  bit         sending;
  bit         exp_chg;
  bit         exp_drop;

  task automatic chk(input string tag, input logic [8*N-1:0] got, input logic [8*N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [8*N-1:0] model_msg();
    logic [8*N-1:0] m;
    for (int i = 0; i < N; i++) m[8*i +: 8] = (i < text.size()) ? text[i] : 8'h20;
    return m;
  endfunction

  task automatic model_reset();
    text.delete();
    sending  = 0;
    exp_chg  = 0;
    exp_drop = 0;
  endtask

  task automatic model_update(input bit kv, input logic [7:0] ka, input bit clr, input bit rdy);
    exp_chg  = 0;
    exp_drop = 0;
    if (clr) begin
      exp_chg = (text.size() > 0);
      text.delete();
      sending = 0;
    end else if (sending) begin
      if (rdy) begin
        text.delete();
        sending = 0;
        exp_chg = 1;
      end
      if (kv) exp_drop = 1;
    end else if (kv) begin
      if (ka >= 8'h20 && ka <= 8'h7E) begin
        if (text.size() < N) begin
          text.push_back(ka);
          exp_chg = 1;
        end else begin
          exp_drop = 1;
        end
      end else if (ka == 8'h08) begin
        if (text.size() > 0) begin
          void'(text.pop_back());
          exp_chg = 1;
        end
      end else if (ka == 8'h0D) begin
        if (text.size() > 0) sending = 1;
      end else begin
        exp_drop = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".message"},     bus.message,                model_msg());
    chk({tag, ".char_count"},  128'(bus.char_count),       128'(text.size()));
    chk({tag, ".send_valid"},  128'(bus.send_valid),       128'(sending));
    chk({tag, ".msg_changed"}, 128'(bus.msg_changed),      128'(exp_chg));
    chk({tag, ".key_dropped"}, 128'(bus.key_dropped),      128'(exp_drop));
  endtask

  // Called at a negedge: apply inputs, clock once, then compare at the next negedge.
  task automatic step(input string tag, input bit kv, input logic [7:0] ka, input bit clr, input bit rdy);
    bus.key_valid  = kv;
    bus.key_ascii  = ka;
    bus.clear      = clr;
    bus.send_ready = rdy;
    @(posedge clock);
    model_update(kv, ka, clr, rdy);
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic key(input string tag, input logic [7:0] ka);
    step(tag, 1'b1, ka, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag, input bit rdy);
    step(tag, 1'b0, 8'h00, 1'b0, rdy);
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return 8'($urandom_range(32, 126));
    if (r < 68) return 8'h08;
    if (r < 80) return 8'h0D;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    reset          = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key_ascii  = 8'h00;
    bus.clear      = 1'b0;
    bus.send_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all("reset");
    reset = 1'b0;

    // Two keys read from the LSB end.
    key("hi_h", 8'h48);
    key("hi_i", 8'h69);
    chk("hi_low16", 128'(bus.message[15:0]), 128'h6948);

    // Overfill: only the 17th key is dropped.
    step("clr0", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < N + 1; i++) key("fill", 8'h41);
    chk("fill_all_A", bus.message, {N{8'h41}});

    // Backspace down past empty.
    step("clr1", 1'b0, 8'h00, 1'b1, 1'b0);
    key("ab_a", 8'h61);
    key("ab_b", 8'h62);
    key("bs1", 8'h08);
    key("bs2", 8'h08);
    key("bs3", 8'h08);

    // Send held off by the receiver; a stray key is dropped.
    key("ok_o", 8'h6F);
    key("ok_k", 8'h6B);
    key("ok_enter", 8'h0D);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) key("hold_x", 8'h78);
      else idle("hold", 1'b0);
    end
    chk("hold_low16", 128'(bus.message[15:0]), 128'h6B6F);
    idle("accept", 1'b1);
    idle("after_accept", 1'b1);

    // ENTER on empty, then clear aborting a pending send.
    key("enter_empty", 8'h0D);
    key("z", 8'h7A);
    key("z_enter", 8'h0D);
    step("abort", 1'b1, 8'h41, 1'b1, 1'b0);

    // Async reset while SEND is pending must act before the next edge.
    key("r_q", 8'h71);
    key("r_enter", 8'h0D);
    bus.key_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clock);
    check_all("async_rst_hold");
    reset = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      bit kv, clr, rdy;
      kv  = ($urandom_range(0, 99) < 60);
      clr = ($urandom_range(0, 99) < 3);
      rdy = ($urandom_range(0, 99) < 30);
      step("rand", kv, rand_key(), clr, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
